reg_bus_arbiter: RTL and testbench

Two-master arbiter for the 8-bit internal register bus (`int_address`, `int_wr_data`, `int_write`, `int_read`, `int_rd_data`) that uart2bus_top currently drives alone. Master 0 is the UART command parser and master 1 is a second host, such as a local controller. The block serialises their single-beat read/write requests onto the register file. It is placed between the masters and the register file, so the register file sees one bus master.

---
 rtl/reg_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two masters share one register bus. Write strobe+ack 1 cycle after grant, read ack 3 cycles after.
// A losing master just keeps req high until granted; REG_ARB_ROUND_ROBIN_EN alternates tie winners, else master 0 wins.
module reg_bus_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_write,
    input  logic          m1_write,
    input  logic [AW-1:0] m0_address,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m0_wr_data,
    input  logic [DW-1:0] m1_wr_data,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic [DW-1:0] m0_rd_data,
    output logic [DW-1:0] m1_rd_data,
    output logic [AW-1:0] int_address,
    output logic [DW-1:0] int_wr_data,
    output logic          int_write,
    output logic          int_read,
    input  logic [DW-1:0] int_rd_data,
    output logic          arb_busy,
    output logic          arb_owner
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RDWAIT,
        ST_RDACK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_owner;
    logic          w_owner_nxt;
    logic [AW-1:0] r_address;
    logic [AW-1:0] w_address_nxt;
    logic [DW-1:0] r_wr_data;
    logic [DW-1:0] w_wr_data_nxt;
    logic          r_write;
    logic          w_write_nxt;
    logic          r_read;
    logic          w_read_nxt;
    logic [1:0]    r_ack;
    logic [1:0]    w_ack_nxt;
    logic [DW-1:0] r_rd_data0;
    logic [DW-1:0] w_rd_data0_nxt;
    logic [DW-1:0] r_rd_data1;
    logic [DW-1:0] w_rd_data1_nxt;
    logic          r_busy;
    logic          w_busy_nxt;

    logic          w_any_req;
    logic          w_winner;
    logic          w_sel_write;
    logic [AW-1:0] w_sel_address;
    logic [DW-1:0] w_sel_wr_data;

    assign w_any_req = m0_req | m1_req;

`ifdef REG_ARB_ROUND_ROBIN_EN
    // r_last_grant remembers the previous winner; a tie goes to the other master.
    logic r_last_grant;

    assign w_winner = (m0_req & m1_req) ? ~r_last_grant : m1_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_last_grant <= w_winner;
        end
    end
`else
    assign w_winner = m1_req & ~m0_req;
`endif

    assign w_sel_write   = w_winner ? m1_write   : m0_write;
    assign w_sel_address = w_winner ? m1_address : m0_address;
    assign w_sel_wr_data = w_winner ? m1_wr_data : m0_wr_data;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_address_nxt  = r_address;
        w_wr_data_nxt  = r_wr_data;
        w_write_nxt    = 1'b0;
        w_read_nxt     = 1'b0;
        w_ack_nxt      = 2'b00;
        w_rd_data0_nxt = r_rd_data0;
        w_rd_data1_nxt = r_rd_data1;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt   = w_winner;
                    w_address_nxt = w_sel_address;
                    w_wr_data_nxt = w_sel_wr_data;
                    // Write strobe and ack are launched together so both land in the WR cycle.
                    if (w_sel_write) begin
                        w_state_nxt          = ST_WR;
                        w_write_nxt          = 1'b1;
                        w_ack_nxt[w_winner]  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RD;
                        w_read_nxt  = 1'b1;
                    end
                end
            end
            ST_WR: begin
                w_state_nxt = ST_IDLE;
            end
            ST_RD: begin
                w_state_nxt = ST_RDWAIT;
            end
            ST_RDWAIT: begin
                if (r_owner) begin
                    w_rd_data1_nxt = int_rd_data;
                end else begin
                    w_rd_data0_nxt = int_rd_data;
                end
                w_ack_nxt[r_owner] = 1'b1;
                w_state_nxt        = ST_RDACK;
            end
            ST_RDACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner    <= 1'b0;
            r_address  <= '0;
            r_wr_data  <= '0;
            r_write    <= 1'b0;
            r_read     <= 1'b0;
            r_ack      <= 2'b00;
            r_rd_data0 <= '0;
            r_rd_data1 <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_owner    <= w_owner_nxt;
            r_address  <= w_address_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_write    <= w_write_nxt;
            r_read     <= w_read_nxt;
            r_ack      <= w_ack_nxt;
            r_rd_data0 <= w_rd_data0_nxt;
            r_rd_data1 <= w_rd_data1_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign m0_ack      = r_ack[0];
    assign m1_ack      = r_ack[1];
    assign m0_rd_data  = r_rd_data0;
    assign m1_rd_data  = r_rd_data1;
    assign int_address = r_address;
    assign int_wr_data = r_wr_data;
    assign int_write   = r_write;
    assign int_read    = r_read;
    assign arb_busy    = r_busy;
    assign arb_owner   = r_owner;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: directed scenarios plus random single/dual-master traffic
// checked against a transaction-level schedule and a register-file model.
module tb_reg_bus_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          m0_req, m1_req, m0_write, m1_write;
    logic [AW-1:0] m0_address, m1_address;
    logic [DW-1:0] m0_wr_data, m1_wr_data;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rd_data, m1_rd_data;
    logic [AW-1:0] int_address;
    logic [DW-1:0] int_wr_data;
    logic          int_write, int_read;
    logic [DW-1:0] int_rd_data;
    logic          arb_busy, arb_owner;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: expected register contents, per-master read results, last grant.
    logic [DW-1:0] mdl_mem [256];
    logic [DW-1:0] exp_rd  [2];
    bit            mdl_last;

    always #5 clock = ~clock;

    reg_bus_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .m0_req      (m0_req),
        .m1_req      (m1_req),
        .m0_write    (m0_write),
        .m1_write    (m1_write),
        .m0_address  (m0_address),
        .m1_address  (m1_address),
        .m0_wr_data  (m0_wr_data),
        .m1_wr_data  (m1_wr_data),
        .m0_ack      (m0_ack),
        .m1_ack      (m1_ack),
        .m0_rd_data  (m0_rd_data),
        .m1_rd_data  (m1_rd_data),
        .int_address (int_address),
        .int_wr_data (int_wr_data),
        .int_write   (int_write),
        .int_read    (int_read),
        .int_rd_data (int_rd_data),
        .arb_busy    (arb_busy),
        .arb_owner   (arb_owner)
    );

    // Register file: unwritten locations read back as address ^ 0x5A.
    logic [DW-1:0] rf_mem     [256];
    bit            rf_written [256];
    logic [DW-1:0] rf_q;

    always @(posedge clock) begin
        if (int_write) begin
            rf_mem[int_address]     <= int_wr_data;
            rf_written[int_address] <= 1'b1;
        end
        if (int_read) rf_q <= rf_written[int_address] ? rf_mem[int_address] : (int_address ^ 8'h5A);
    end
    assign int_rd_data = rf_q;

    function automatic bit tie_winner();
`ifdef REG_ARB_ROUND_ROBIN_EN
        return !mdl_last;
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        n_total++; if ({m0_ack, m1_ack, int_write, int_read, arb_busy, arb_owner} !== 6'b0) $display("FAIL reset_ctrl: got %b want 000000", {m0_ack, m1_ack, int_write, int_read, arb_busy, arb_owner}); else n_pass++;
        n_total++; if ({m0_rd_data, m1_rd_data, int_address, int_wr_data} !== 32'h0) $display("FAIL reset_data: got %h want 0", {m0_rd_data, m1_rd_data, int_address, int_wr_data}); else n_pass++;
        reset = 1'b1;
        tick();
        n_total++; if ({int_write, int_read, arb_busy} !== 3'b0) $display("FAIL reset_idle: got %b want 000", {int_write, int_read, arb_busy}); else n_pass++;
    endtask

    task automatic test_write_single();
        n_total++; if (arb_busy !== 1'b0) $display("FAIL wr1_busy_n: got %b want 0", arb_busy); else n_pass++;
        m0_write = 1'b1; m0_address = 8'h1A; m0_wr_data = 8'h4C; m0_req = 1'b1;
        tick();
        n_total++; if (int_write !== 1'b1) $display("FAIL wr1_strobe: got %b want 1", int_write); else n_pass++;
        n_total++; if (int_address !== 8'h1A) $display("FAIL wr1_addr: got %h want 1a", int_address); else n_pass++;
        n_total++; if (int_wr_data !== 8'h4C) $display("FAIL wr1_data: got %h want 4c", int_wr_data); else n_pass++;
        n_total++; if ({m1_ack, m0_ack} !== 2'b01) $display("FAIL wr1_ack: got %b want 01", {m1_ack, m0_ack}); else n_pass++;
        n_total++; if (arb_busy !== 1'b1) $display("FAIL wr1_busy: got %b want 1", arb_busy); else n_pass++;
        n_total++; if (arb_owner !== 1'b0) $display("FAIL wr1_owner: got %b want 0", arb_owner); else n_pass++;
        m0_req = 1'b0; mdl_mem[8'h1A] = 8'h4C; mdl_last = 1'b0;
        tick();
        n_total++; if ({int_write, m0_ack, m1_ack, arb_busy} !== 4'b0) $display("FAIL wr1_after: got %b want 0000", {int_write, m0_ack, m1_ack, arb_busy}); else n_pass++;
        n_total++; if (int_address !== 8'h1A) $display("FAIL wr1_hold: got %h want 1a", int_address); else n_pass++;
    endtask

    task automatic test_read_single();
        m1_write = 1'b0; m1_address = 8'h1A; m1_wr_data = 8'h00; m1_req = 1'b1;
        tick();
        n_total++; if ({int_read, int_write} !== 2'b10) $display("FAIL rd1_strobe: got %b want 10", {int_read, int_write}); else n_pass++;
        n_total++; if (arb_owner !== 1'b1) $display("FAIL rd1_owner: got %b want 1", arb_owner); else n_pass++;
        n_total++; if (m1_ack !== 1'b0) $display("FAIL rd1_early_ack1: got %b want 0", m1_ack); else n_pass++;
        tick();
        n_total++; if ({int_read, m1_ack, arb_busy} !== 3'b001) $display("FAIL rd1_wait: got %b want 001", {int_read, m1_ack, arb_busy}); else n_pass++;
        tick();
        n_total++; if ({m1_ack, m0_ack} !== 2'b10) $display("FAIL rd1_ack: got %b want 10", {m1_ack, m0_ack}); else n_pass++;
        n_total++; if (m1_rd_data !== mdl_mem[8'h1A]) $display("FAIL rd1_data: got %h want %h", m1_rd_data, mdl_mem[8'h1A]); else n_pass++;
        n_total++; if (m0_rd_data !== exp_rd[0]) $display("FAIL rd1_other: got %h want %h", m0_rd_data, exp_rd[0]); else n_pass++;
        m1_req = 1'b0; exp_rd[1] = mdl_mem[8'h1A]; mdl_last = 1'b1;
        tick();
        n_total++; if ({m1_ack, arb_busy} !== 2'b00) $display("FAIL rd1_after: got %b want 00", {m1_ack, arb_busy}); else n_pass++;
        n_total++; if (m1_rd_data !== exp_rd[1]) $display("FAIL rd1_held: got %h want %h", m1_rd_data, exp_rd[1]); else n_pass++;
    endtask

    task automatic run_tie_writes(input string tag);
        bit first;
        bit second;
        first  = tie_winner();
        second = !first;
        m0_write = 1'b1; m0_address = 8'h01; m0_wr_data = 8'h11;
        m1_write = 1'b1; m1_address = 8'h02; m1_wr_data = 8'h22;
        m0_req = 1'b1; m1_req = 1'b1;
        tick();
        n_total++; if (int_write !== 1'b1) $display("FAIL %s_strobe1: got %b want 1", tag, int_write); else n_pass++;
        n_total++; if (arb_owner !== first) $display("FAIL %s_owner1: got %b want %b", tag, arb_owner, first); else n_pass++;
        n_total++; if ({int_address, int_wr_data} !== (first ? 16'h0222 : 16'h0111)) $display("FAIL %s_bus1: got %h want %h", tag, {int_address, int_wr_data}, first ? 16'h0222 : 16'h0111); else n_pass++;
        n_total++; if ({m1_ack, m0_ack} !== (first ? 2'b10 : 2'b01)) $display("FAIL %s_ack1: got %b want %b", tag, {m1_ack, m0_ack}, first ? 2'b10 : 2'b01); else n_pass++;
        if (first) m1_req = 1'b0; else m0_req = 1'b0;
        mdl_mem[first ? 8'h02 : 8'h01] = first ? 8'h22 : 8'h11; mdl_last = first;
        tick();
        n_total++; if ({int_write, m0_ack, m1_ack} !== 3'b0) $display("FAIL %s_gap: got %b want 000", tag, {int_write, m0_ack, m1_ack}); else n_pass++;
        tick();
        n_total++; if (int_write !== 1'b1) $display("FAIL %s_strobe2: got %b want 1", tag, int_write); else n_pass++;
        n_total++; if (arb_owner !== second) $display("FAIL %s_owner2: got %b want %b", tag, arb_owner, second); else n_pass++;
        n_total++; if ({int_address, int_wr_data} !== (second ? 16'h0222 : 16'h0111)) $display("FAIL %s_bus2: got %h want %h", tag, {int_address, int_wr_data}, second ? 16'h0222 : 16'h0111); else n_pass++;
        n_total++; if ({m1_ack, m0_ack} !== (second ? 2'b10 : 2'b01)) $display("FAIL %s_ack2: got %b want %b", tag, {m1_ack, m0_ack}, second ? 2'b10 : 2'b01); else n_pass++;
        if (second) m1_req = 1'b0; else m0_req = 1'b0;
        mdl_mem[second ? 8'h02 : 8'h01] = second ? 8'h22 : 8'h11; mdl_last = second;
        tick();
        n_total++; if ({int_write, arb_busy} !== 2'b00) $display("FAIL %s_end: got %b want 00", tag, {int_write, arb_busy}); else n_pass++;
    endtask

    task automatic test_tie();
        reset = 1'b0;
        tick();
        reset = 1'b1; mdl_last = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0;
        run_tie_writes("tie1");
    endtask

    task automatic test_second_tie();
        run_tie_writes("tie2");
    endtask

    task automatic test_reset_mid_read();
        m0_write = 1'b0; m0_address = 8'h02; m0_wr_data = 8'h00; m0_req = 1'b1;
        tick();
        n_total++; if (int_read !== 1'b1) $display("FAIL rst_rd_strobe: got %b want 1", int_read); else n_pass++;
        tick();
        n_total++; if (arb_busy !== 1'b1) $display("FAIL rst_rd_busy: got %b want 1", arb_busy); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if ({m0_ack, m1_ack, int_write, int_read, arb_busy, arb_owner, int_address, int_wr_data, m0_rd_data, m1_rd_data} !== 38'h0) $display("FAIL rst_rd_zero: got %h want 0", {m0_ack, m1_ack, int_write, int_read, arb_busy, arb_owner, int_address, int_wr_data, m0_rd_data, m1_rd_data}); else n_pass++;
        exp_rd[0] = '0; exp_rd[1] = '0; mdl_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if ({m0_ack, m1_ack, arb_busy} !== 3'b0) $display("FAIL rst_rd_noack: got %b want 000", {m0_ack, m1_ack, arb_busy}); else n_pass++;
        end
        reset = 1'b1;
        tick();
        n_total++; if ({int_read, int_address} !== 9'h102) $display("FAIL rst_rd_restart: got %h want 102", {int_read, int_address}); else n_pass++;
        tick();
        n_total++; if ({int_read, m0_ack, arb_busy} !== 3'b001) $display("FAIL rst_rd_wait: got %b want 001", {int_read, m0_ack, arb_busy}); else n_pass++;
        tick();
        n_total++; if (m0_ack !== 1'b1) $display("FAIL rst_rd_ack: got %b want 1", m0_ack); else n_pass++;
        n_total++; if (m0_rd_data !== mdl_mem[8'h02]) $display("FAIL rst_rd_data: got %h want %h", m0_rd_data, mdl_mem[8'h02]); else n_pass++;
        m0_req = 1'b0; exp_rd[0] = mdl_mem[8'h02]; mdl_last = 1'b0;
        tick();
        n_total++; if ({m0_ack, arb_busy} !== 2'b00) $display("FAIL rst_rd_end: got %b want 00", {m0_ack, arb_busy}); else n_pass++;
    endtask

    task automatic test_back_to_back();
        m0_write = 1'b1; m0_address = 8'h30; m0_wr_data = 8'hA5; m0_req = 1'b1;
        tick();
        n_total++; if ({int_write, m0_ack, int_address, int_wr_data} !== 18'h330A5) $display("FAIL b2b_first: got %h want 330a5", {int_write, m0_ack, int_address, int_wr_data}); else n_pass++;
        m0_req = 1'b0; mdl_mem[8'h30] = 8'hA5; mdl_last = 1'b0;
        m1_write = 1'b1; m1_address = 8'h31; m1_wr_data = 8'h5C; m1_req = 1'b1;
        tick();
        n_total++; if ({int_write, int_address, int_wr_data} !== 17'h030A5) $display("FAIL b2b_gap: got %h want 030a5", {int_write, int_address, int_wr_data}); else n_pass++;
        tick();
        n_total++; if ({int_write, m1_ack, arb_owner, int_address, int_wr_data} !== 19'h7315C) $display("FAIL b2b_second: got %h want 7315c", {int_write, m1_ack, arb_owner, int_address, int_wr_data}); else n_pass++;
        m1_req = 1'b0; mdl_mem[8'h31] = 8'h5C; mdl_last = 1'b1;
        tick();
        n_total++; if ({int_write, m1_ack, arb_busy} !== 3'b0) $display("FAIL b2b_end: got %b want 000", {int_write, m1_ack, arb_busy}); else n_pass++;
    endtask

    task automatic test_random();
        bit            t_wr   [2];
        logic [AW-1:0] t_addr [2];
        logic [DW-1:0] t_dat  [2];
        bit            ord    [2];
        int            s_cyc  [2];
        int            a_cyc  [2];
        int            n_txn;
        int            sel;
        bit            mk;
        bit            exp_w, exp_r, exp_busy, have_cur, cur_owner;
        bit [1:0]      exp_ack;
        logic [AW-1:0] cur_addr;
        logic [DW-1:0] cur_dat;
        for (int it = 0; it < 60; it++) begin
            tick();
            have_cur = 1'b0; cur_owner = 1'b0; cur_addr = '0; cur_dat = '0;
            sel = $urandom_range(1, 3);
            for (int m = 0; m < 2; m++) begin
                t_wr[m]   = 1'($urandom_range(0, 1));
                t_addr[m] = AW'($urandom_range(0, 15));
                t_dat[m]  = DW'($urandom);
            end
            m0_write = t_wr[0]; m0_address = t_addr[0]; m0_wr_data = t_dat[0];
            m1_write = t_wr[1]; m1_address = t_addr[1]; m1_wr_data = t_dat[1];
            m0_req = (sel != 2); m1_req = (sel != 1);
            if (sel == 3) begin
                ord[0] = tie_winner(); n_txn = 2;
            end else begin
                ord[0] = (sel == 2); n_txn = 1;
            end
            ord[1]   = !ord[0];
            s_cyc[0] = 1;
            a_cyc[0] = s_cyc[0] + (t_wr[ord[0]] ? 0 : 2);
            s_cyc[1] = a_cyc[0] + 2;
            a_cyc[1] = s_cyc[1] + (t_wr[ord[1]] ? 0 : 2);
            for (int c = 1; c <= a_cyc[n_txn-1] + 1; c++) begin
                tick();
                exp_w = 1'b0; exp_r = 1'b0; exp_busy = 1'b0; exp_ack = 2'b00;
                for (int k = 0; k < n_txn; k++) begin
                    mk = ord[k];
                    if (c == s_cyc[k]) begin
                        if (t_wr[mk]) begin
                            exp_w = 1'b1;
                            mdl_mem[t_addr[mk]] = t_dat[mk];
                        end else begin
                            exp_r = 1'b1;
                        end
                        cur_addr = t_addr[mk]; cur_dat = t_dat[mk]; cur_owner = mk;
                        have_cur = 1'b1; mdl_last = mk;
                    end
                    if (c == a_cyc[k]) begin
                        exp_ack[mk] = 1'b1;
                        if (!t_wr[mk]) exp_rd[mk] = mdl_mem[t_addr[mk]];
                    end
                    if (c >= s_cyc[k] && c <= a_cyc[k]) exp_busy = 1'b1;
                end
                n_total++; if ({int_write, int_read} !== {exp_w, exp_r}) $display("FAIL rnd_strobe it=%0d c=%0d: got %b want %b", it, c, {int_write, int_read}, {exp_w, exp_r}); else n_pass++;
                n_total++; if ({m1_ack, m0_ack} !== exp_ack) $display("FAIL rnd_ack it=%0d c=%0d: got %b want %b", it, c, {m1_ack, m0_ack}, exp_ack); else n_pass++;
                n_total++; if (arb_busy !== exp_busy) $display("FAIL rnd_busy it=%0d c=%0d: got %b want %b", it, c, arb_busy, exp_busy); else n_pass++;
                n_total++; if (m0_rd_data !== exp_rd[0]) $display("FAIL rnd_rd0 it=%0d c=%0d: got %h want %h", it, c, m0_rd_data, exp_rd[0]); else n_pass++;
                n_total++; if (m1_rd_data !== exp_rd[1]) $display("FAIL rnd_rd1 it=%0d c=%0d: got %h want %h", it, c, m1_rd_data, exp_rd[1]); else n_pass++;
                if (have_cur) begin
                    n_total++; if ({arb_owner, int_address, int_wr_data} !== {cur_owner, cur_addr, cur_dat}) $display("FAIL rnd_bus it=%0d c=%0d: got %h want %h", it, c, {arb_owner, int_address, int_wr_data}, {cur_owner, cur_addr, cur_dat}); else n_pass++;
                end
                if (exp_ack[0]) m0_req = 1'b0;
                if (exp_ack[1]) m1_req = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 1'b0; m1_req = 1'b0; m0_write = 1'b0; m1_write = 1'b0;
        m0_address = '0; m1_address = '0; m0_wr_data = '0; m1_wr_data = '0;
        for (int i = 0; i < 256; i++) mdl_mem[i] = DW'(i) ^ 8'h5A;
        exp_rd[0] = '0; exp_rd[1] = '0; mdl_last = 1'b1;
        test_reset();
        test_write_single();
        test_read_single();
        test_tie();
        test_second_tie();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
